// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive sequencer and its environment (line, baud generator, shifter).
// Optional build macro: UART_RX_CTRL_PARITY_EN adds the parity_err output.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] par_in;
  logic                 shift_en;
  logic                 shift_data;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_RX_CTRL_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    output baud_tick, rx, par_in,
`ifdef UART_RX_CTRL_PARITY_EN
    input  parity_err,
`endif
    input  shift_en, shift_data, rx_data, rx_valid, frame_err, busy
  );

  modport slave (
    input  baud_tick, rx, par_in,
`ifdef UART_RX_CTRL_PARITY_EN
    output parity_err,
`endif
    output shift_en, shift_data, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, mid-bit sampling on the 16x tick, shifter control, stop check.
// Optional build macro: UART_RX_CTRL_PARITY_EN inserts an even-parity bit between data and stop.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_ctrl_if.slave  bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE/2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_CTRL_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t               state_q;
  logic                 rx_meta_q, rx_s_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic                 shift_en_q, shift_data_q;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, frame_err_q, busy_q;
`ifdef UART_RX_CTRL_PARITY_EN
  logic                 par_acc_q, par_bad_q, parity_err_q;
`endif

  // The shifter fills from q[0] upward, so the first bit on the line ends up in the MSB.
  always_comb begin
    rx_data_d = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      rx_data_d[i] = bus.par_in[DATA_BITS-1-i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_en_q   <= 1'b0;
      shift_data_q <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_CTRL_PARITY_EN
      par_acc_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= bus.rx;
      rx_s_q      <= rx_meta_q;
      shift_en_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_CTRL_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (bus.baud_tick) begin
        unique case (state_q)
          IDLE: begin
            if (!rx_s_q) begin
              state_q    <= START;
              tick_cnt_q <= '0;
              busy_q     <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt_q == TICK_MID) begin
              if (rx_s_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q    <= DATA;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
`ifdef UART_RX_CTRL_PARITY_EN
                par_acc_q  <= 1'b0;
`endif
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt_q == TICK_LAST) begin
              shift_data_q <= rx_s_q;
              shift_en_q   <= 1'b1;
              tick_cnt_q   <= '0;
`ifdef UART_RX_CTRL_PARITY_EN
              par_acc_q    <= par_acc_q ^ rx_s_q;
`endif
              if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_q <= '0;
`ifdef UART_RX_CTRL_PARITY_EN
                state_q   <= PARITY;
`else
                state_q   <= STOP;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`ifdef UART_RX_CTRL_PARITY_EN
          PARITY: begin
            if (tick_cnt_q == TICK_LAST) begin
              par_bad_q  <= par_acc_q ^ rx_s_q;
              tick_cnt_q <= '0;
              state_q    <= STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`endif
          STOP: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              if (rx_s_q) begin
                rx_data_q  <= rx_data_d;
                rx_valid_q <= 1'b1;
`ifdef UART_RX_CTRL_PARITY_EN
                parity_err_q <= par_bad_q;
`endif
                state_q    <= IDLE;
                busy_q     <= 1'b0;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= BREAK;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          // A line stuck low must return high before another start bit can be seen.
          BREAK: begin
            if (rx_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.shift_en   = shift_en_q;
  assign bus.shift_data = shift_data_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;
`ifdef UART_RX_CTRL_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives serial frames on a 4-clk baud tick and models the external shifter.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  localparam int OS = 16;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();
  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.baud_tick = 1'b1;
      @(negedge clk);
      bus.baud_tick = 1'b0;
    end
  end

  // External shifter: serial in lands at q[0], older bits move up.
  logic [DB-1:0] sh_q = '0;
  always @(posedge clk) if (bus.shift_en) sh_q <= {sh_q[DB-2:0], bus.shift_data};
  assign bus.par_in = sh_q;

  int cyc = 0, last_tick_cyc = 0, lat_last = -1;
  int se_cnt = 0, se_consec = 0, valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, perr_alone = 0;
  logic [63:0] se_hist = '0;
  logic prev_se = 1'b0;
  logic [DB-1:0] vdata[$];

  always @(posedge clk) begin
    cyc++;
    if (bus.baud_tick) last_tick_cyc = cyc;
  end

  always @(negedge clk) begin
    if (bus.shift_en) begin
      se_cnt++;
      se_hist = {se_hist[62:0], bus.shift_data};
      if (prev_se) se_consec++;
    end
    prev_se = bus.shift_en;
    if (bus.rx_valid) begin
      valid_cnt++;
      vdata.push_back(bus.rx_data);
      lat_last = cyc - last_tick_cyc;
    end
    if (bus.frame_err) ferr_cnt++;
`ifdef UART_RX_CTRL_PARITY_EN
    if (bus.parity_err) perr_cnt++;
    if (bus.parity_err && !bus.rx_valid) perr_alone++;
`endif
  end

  function automatic logic [7:0] rev8(input logic [7:0] d);
    for (int i = 0; i < 8; i++) rev8[i] = d[7-i];
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.baud_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    wait_ticks(OS);
  endtask

  // Start bit, data LSB first, optional parity bit (par < 0 means none); stop bit left to the caller.
  task automatic send_body(input logic [7:0] d, input int par);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (par >= 0) send_bit(par[0]);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_body(d, -1);
    send_bit(1'b1);
  endtask

  task automatic test_reset;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.shift_en !== 1'b0)   begin n_bad++; $display("FAIL reset_shift_en: got %b want 0", bus.shift_en); end
    n_cmp++; if (bus.shift_data !== 1'b1) begin n_bad++; $display("FAIL reset_shift_data: got %b want 1", bus.shift_data); end
    n_cmp++; if (bus.rx_data !== 8'h00)   begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
    n_cmp++; if (bus.rx_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
    n_cmp++; if (bus.frame_err !== 1'b0)  begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    n_cmp++; if (bus.busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_basic_frame;
    int s0, v0, f0;
    s0 = se_cnt; v0 = valid_cnt; f0 = ferr_cnt;
    send_good(8'hA5);
    wait_ticks(2);
    n_cmp++; if (se_cnt - s0 !== 8)            begin n_bad++; $display("FAIL a5_shift_count: got %0d want 8", se_cnt - s0); end
    n_cmp++; if (se_hist[7:0] !== rev8(8'hA5)) begin n_bad++; $display("FAIL a5_shift_bits: got %b want %b", se_hist[7:0], rev8(8'hA5)); end
    n_cmp++; if (valid_cnt - v0 !== 1)         begin n_bad++; $display("FAIL a5_valid_count: got %0d want 1", valid_cnt - v0); end
    n_cmp++; if (bus.rx_data !== 8'hA5)        begin n_bad++; $display("FAIL a5_rx_data: got %h want a5", bus.rx_data); end
    n_cmp++; if (lat_last !== 0)               begin n_bad++; $display("FAIL a5_valid_latency: got %0d want 0 cycles past tick edge", lat_last); end
    n_cmp++; if (ferr_cnt - f0 !== 0)          begin n_bad++; $display("FAIL a5_frame_err: got %0d want 0", ferr_cnt - f0); end
    n_cmp++; if (bus.busy !== 1'b0)            begin n_bad++; $display("FAIL a5_busy_after: got %b want 0", bus.busy); end
    n_cmp++; if (se_consec !== 0)              begin n_bad++; $display("FAIL a5_shift_consecutive: got %0d want 0", se_consec); end
  endtask

  task automatic test_glitch;
    int s0, v0;
    s0 = se_cnt; v0 = valid_cnt;
    bus.rx = 1'b0;
    wait_ticks(3);
    bus.rx = 1'b1;
    wait_ticks(5);
    n_cmp++; if (bus.busy !== 1'b1)    begin n_bad++; $display("FAIL glitch_busy_tick8: got %b want 1", bus.busy); end
    wait_ticks(1);
    n_cmp++; if (bus.busy !== 1'b0)    begin n_bad++; $display("FAIL glitch_busy_tick9: got %b want 0", bus.busy); end
    wait_ticks(20);
    n_cmp++; if (se_cnt - s0 !== 0)    begin n_bad++; $display("FAIL glitch_shift_count: got %0d want 0", se_cnt - s0); end
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL glitch_valid_count: got %0d want 0", valid_cnt - v0); end
  endtask

  task automatic test_frame_err;
    int s0, v0, f0;
    send_good(8'h3C);
    wait_ticks(2);
    n_cmp++; if (bus.rx_data !== 8'h3C)  begin n_bad++; $display("FAIL ferr_pre_rx_data: got %h want 3c", bus.rx_data); end
    s0 = se_cnt; v0 = valid_cnt; f0 = ferr_cnt;
    send_body(8'h55, -1);
    bus.rx = 1'b0;
    wait_ticks(40);
    n_cmp++; if (ferr_cnt - f0 !== 1)    begin n_bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
    n_cmp++; if (valid_cnt - v0 !== 0)   begin n_bad++; $display("FAIL ferr_valid_count: got %0d want 0", valid_cnt - v0); end
    n_cmp++; if (bus.rx_data !== 8'h3C)  begin n_bad++; $display("FAIL ferr_rx_data_held: got %h want 3c", bus.rx_data); end
    n_cmp++; if (se_cnt - s0 !== 8)      begin n_bad++; $display("FAIL ferr_shift_count: got %0d want 8", se_cnt - s0); end
    n_cmp++; if (bus.busy !== 1'b1)      begin n_bad++; $display("FAIL ferr_busy_in_break: got %b want 1", bus.busy); end
    bus.rx = 1'b1;
    wait_ticks(2);
    n_cmp++; if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL ferr_busy_after_break: got %b want 0", bus.busy); end
    wait_ticks(4);
    send_good(8'h81);
    wait_ticks(2);
    n_cmp++; if (valid_cnt - v0 !== 1)   begin n_bad++; $display("FAIL ferr_next_valid: got %0d want 1", valid_cnt - v0); end
    n_cmp++; if (bus.rx_data !== 8'h81)  begin n_bad++; $display("FAIL ferr_next_rx_data: got %h want 81", bus.rx_data); end
    n_cmp++; if (ferr_cnt - f0 !== 1)    begin n_bad++; $display("FAIL ferr_no_extra: got %0d want 1", ferr_cnt - f0); end
  endtask

  task automatic test_back_to_back;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_good(8'h00);
    send_good(8'hFF);
    wait_ticks(2);
    n_cmp++; if (valid_cnt - v0 !== 2) begin n_bad++; $display("FAIL b2b_valid_count: got %0d want 2", valid_cnt - v0); end
    if (vdata.size() >= v0 + 2) begin
      n_cmp++; if (vdata[v0] !== 8'h00)   begin n_bad++; $display("FAIL b2b_first: got %h want 00", vdata[v0]); end
      n_cmp++; if (vdata[v0+1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_second: got %h want ff", vdata[v0+1]); end
    end
    n_cmp++; if (ferr_cnt - f0 !== 0)  begin n_bad++; $display("FAIL b2b_frame_err: got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid;
    int s0, v0, f0;
    logic [7:0] d;
    d = 8'h96;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    n_cmp++; if (bus.busy !== 1'b1)       begin n_bad++; $display("FAIL rmid_busy_before: got %b want 1", bus.busy); end
    reset = 1'b1;
    bus.rx = 1'b1;
    #1;
    n_cmp++; if (bus.shift_data !== 1'b1) begin n_bad++; $display("FAIL rmid_shift_data: got %b want 1", bus.shift_data); end
    n_cmp++; if (bus.rx_data !== 8'h00)   begin n_bad++; $display("FAIL rmid_rx_data: got %h want 00", bus.rx_data); end
    n_cmp++; if (bus.busy !== 1'b0)       begin n_bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.shift_en !== 1'b0)   begin n_bad++; $display("FAIL rmid_shift_en: got %b want 0", bus.shift_en); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ticks(20);
    n_cmp++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0)
      begin n_bad++; $display("FAIL rmid_no_pulse: got valid %0d ferr %0d want 0 0", valid_cnt - v0, ferr_cnt - f0); end
    s0 = se_cnt;
    send_good(8'h42);
    wait_ticks(2);
    n_cmp++; if (valid_cnt - v0 !== 1)    begin n_bad++; $display("FAIL rmid_next_valid: got %0d want 1", valid_cnt - v0); end
    n_cmp++; if (bus.rx_data !== 8'h42)   begin n_bad++; $display("FAIL rmid_next_rx_data: got %h want 42", bus.rx_data); end
    n_cmp++; if (se_cnt - s0 !== 8)       begin n_bad++; $display("FAIL rmid_next_shift_count: got %0d want 8", se_cnt - s0); end
  endtask

`ifdef UART_RX_CTRL_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = valid_cnt; p0 = perr_cnt;
    send_body(8'h07, 1);
    send_bit(1'b1);
    wait_ticks(2);
    n_cmp++; if (valid_cnt - v0 !== 1)  begin n_bad++; $display("FAIL par_good_valid: got %0d want 1", valid_cnt - v0); end
    n_cmp++; if (perr_cnt - p0 !== 0)   begin n_bad++; $display("FAIL par_good_perr: got %0d want 0", perr_cnt - p0); end
    n_cmp++; if (bus.rx_data !== 8'h07) begin n_bad++; $display("FAIL par_good_rx_data: got %h want 07", bus.rx_data); end
    send_body(8'h07, 0);
    send_bit(1'b1);
    wait_ticks(2);
    n_cmp++; if (valid_cnt - v0 !== 2)  begin n_bad++; $display("FAIL par_bad_valid: got %0d want 2", valid_cnt - v0); end
    n_cmp++; if (perr_cnt - p0 !== 1)   begin n_bad++; $display("FAIL par_bad_perr: got %0d want 1", perr_cnt - p0); end
    n_cmp++; if (perr_alone !== 0)      begin n_bad++; $display("FAIL par_bad_alignment: got %0d want 0", perr_alone); end
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_basic_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_CTRL_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
